// File: rtl/idea_a.sv
// -----------------------------------------------------------------------------
// idea_a -- 4-bit enabled up-counter instrumented for switching-activity study.
//
// The counter value is presented on VAL, Gray-coded when the GRAY_CODE_EN
// macro is defined (one VAL bit flips per step) and plain binary otherwise.
// Alongside it the block exposes the raw binary count and a running tally of
// VAL bit toggles. Power-estimation logic uses that tally to compare the two
// encodings.
//
// Configuration macro:
//   GRAY_CODE_EN  defined   -> VAL = gray(cnt)
//                 undefined -> VAL = cnt (binary), default build
//
// Ports:
//   C1K            in   1  system clock, rising-edge active
//   RST            in   1  asynchronous active-low reset
//   CE             in   1  count enable, sampled on the rising edge of C1K
//   VAL            out  4  presented counter value (Gray or binary)
//   LOG_LOGIC      out  4  binary count of accepted enables since reset, mod 16
//   LOG_SWITCHING  out  4  accumulated VAL bit toggles since reset, mod 16
//
// All outputs are driven straight from registers. No input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module idea_a (
  input  logic       C1K,
  input  logic       RST,
  input  logic       CE,
  output logic [3:0] VAL,
  output logic [3:0] LOG_LOGIC,
  output logic [3:0] LOG_SWITCHING
);

  // Number of set bits in a 4-bit vector. The result fits in 3 bits, and it is
  // widened to 4 bits here so the accumulator add stays width-matched.
  function automatic logic [3:0] popcount4(input logic [3:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // Encodes a binary count into the form that appears on VAL.
  function automatic logic [3:0] encode(input logic [3:0] b);
`ifdef GRAY_CODE_EN
    return b ^ (b >> 1);
`else
    return b;
`endif
  endfunction

  logic [3:0] cnt_q, cnt_d;
  logic [3:0] val_q, val_d;
  logic [3:0] sw_q,  sw_d;

  // Next-state logic. The toggle tally uses the VAL value before and after the
  // step, so it counts exactly the bits that flip on the output pins. In the
  // default binary build that includes the 4-bit flip on the 15 -> 0 wrap.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned; otherwise synthesis would infer a latch to hold it.
    cnt_d = cnt_q;
    val_d = val_q;
    sw_d  = sw_q;
    if (CE) begin
      cnt_d = cnt_q + 4'd1;                         // wraps 1111 -> 0000
      val_d = encode(cnt_d);
      sw_d  = sw_q + popcount4(val_q ^ val_d);      // mod-16 wrap is intended
    end
  end

  // State registers. A low RST clears everything at once, even in the middle of
  // a clock period. Release is assumed to be synchronous to C1K upstream.
  always_ff @(posedge C1K or negedge RST) begin
    if (!RST) begin
      cnt_q <= 4'd0;
      val_q <= 4'd0;
      sw_q  <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All three
      // registers then update together from the pre-edge values, so
      // simulation matches the synthesized flops.
      cnt_q <= cnt_d;
      val_q <= val_d;
      sw_q  <= sw_d;
    end
  end

  assign VAL           = val_q;
  assign LOG_LOGIC     = cnt_q;
  assign LOG_SWITCHING = sw_q;

endmodule

// File: tb/tb_idea_a.sv
// -----------------------------------------------------------------------------
// tb_idea_a -- self-checking bench for idea_a.
//
// The stimulus process drives RST/CE and pushes the expected outputs into a
// queue after each rising edge. A separate monitor pops and compares entries
// on the falling edge, or immediately on an explicit sample event, which is
// used for the asynchronous-reset check. Expected values come from a small
// model that uses a hand-written Gray table, plus hand-computed checkpoints.
// The bench follows whichever build (GRAY_CODE_EN or not) the RTL is compiled
// with.
// -----------------------------------------------------------------------------
module tb_idea_a;

  typedef struct {
    string      name;
    logic [3:0] val;
    logic [3:0] cnt;
    logic [3:0] sw;
  } exp_t;

  logic       C1K;
  logic       RST;
  logic       CE;
  logic [3:0] VAL;
  logic [3:0] LOG_LOGIC;
  logic [3:0] LOG_SWITCHING;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  event chk_ev;

  // Reference model state.
  logic [3:0] m_cnt, m_val, m_sw;

  idea_a dut (
    .C1K           (C1K),
    .RST           (RST),
    .CE            (CE),
    .VAL           (VAL),
    .LOG_LOGIC     (LOG_LOGIC),
    .LOG_SWITCHING (LOG_SWITCHING)
  );

  initial C1K = 1'b0;
  always #5 C1K = ~C1K;

  // Hand-written reflected Gray sequence for 0..15.
  function automatic logic [3:0] gray_tbl(input logic [3:0] i);
    logic [3:0] t [16];
    t = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
          4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    return t[i];
  endfunction

  function automatic logic [3:0] ones(input logic [3:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 4; i++) if (v[i]) n = n + 4'd1;
    return n;
  endfunction

  task automatic model_step(input logic ce, input logic rst_n);
    logic [3:0] nv;
    if (!rst_n) begin
      m_cnt = 4'd0; m_val = 4'd0; m_sw = 4'd0;
    end else if (ce) begin
      m_cnt = m_cnt + 4'd1;
`ifdef GRAY_CODE_EN
      nv = gray_tbl(m_cnt);
`else
      nv = m_cnt;
`endif
      m_sw  = m_sw + ones(m_val ^ nv);
      m_val = nv;
    end
  endtask

  task automatic push(input string name, input logic [3:0] v, input logic [3:0] c,
                      input logic [3:0] s);
    exp_t e;
    e.name = name; e.val = v; e.cnt = c; e.sw = s;
    exp_q.push_back(e);
  endtask

  // One clock edge with the given CE. The model result is queued for checking.
  task automatic do_edge(input logic ce, input string name);
    CE = ce;
    @(posedge C1K);
    #1;
    model_step(ce, RST);
    push(name, m_val, m_cnt, m_sw);
  endtask

  // Monitor: compare every queued expectation at each sample point.
  always begin
    @(negedge C1K or chk_ev);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (VAL !== e.val || LOG_LOGIC !== e.cnt || LOG_SWITCHING !== e.sw) begin
        n_err++;
        $display("FAIL %s: got VAL=%b LOG_LOGIC=%b LOG_SWITCHING=%b, want VAL=%b LOG_LOGIC=%b LOG_SWITCHING=%b",
                 e.name, VAL, LOG_LOGIC, LOG_SWITCHING, e.val, e.cnt, e.sw);
      end
    end
  end

  // Watchdog.
  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    m_cnt = 4'd0; m_val = 4'd0; m_sw = 4'd0;
    RST = 1'b0;
    CE  = 1'b1;

    // Reset held with the clock running and CE high: everything stays at zero.
    for (int i = 0; i < 4; i++) do_edge(1'b1, "reset_hold");
    push("reset_hold_const", 4'b0000, 4'b0000, 4'b0000);

    // Release away from the rising edge.
    @(negedge C1K);
    #1;
    RST = 1'b1;

    // Count through a full period. Hand-computed checkpoints sit next to the
    // model entries.
    for (int i = 1; i <= 16; i++) begin
      do_edge(1'b1, "count");
`ifdef GRAY_CODE_EN
      if (i == 3)  push("gray_3",  4'b0010, 4'b0011, 4'b0011);
      if (i == 15) push("gray_15", 4'b1000, 4'b1111, 4'b1111);
      if (i == 16) push("gray_16", 4'b0000, 4'b0000, 4'b0000);
`else
      if (i == 4)  push("bin_4",   4'b0100, 4'b0100, 4'b0111);
      if (i == 15) push("bin_15",  4'b1111, 4'b1111, 4'b1010);
      if (i == 16) push("bin_16",  4'b0000, 4'b0000, 4'b1110);
`endif
    end

    // CE gating: high 2, low 2, repeated over 12 edges -> 6 increments.
    for (int i = 0; i < 12; i++) do_edge((i % 4) < 2, "ce_gate");
`ifdef GRAY_CODE_EN
    push("ce_gate_end", 4'b0101, 4'b0110, 4'b0110);
`else
    push("ce_gate_end", 4'b0110, 4'b0110, 4'b1000);
`endif

    // A few more counts, then assert reset asynchronously mid-period.
    for (int i = 0; i < 3; i++) do_edge(1'b1, "pre_async");
    @(negedge C1K);
    #2;
    RST = 1'b0;
    #1;
    model_step(1'b1, 1'b0);
    push("async_reset", 4'b0000, 4'b0000, 4'b0000);
    -> chk_ev;

    // Keep reset low through an edge with CE high: reset wins.
    do_edge(1'b1, "reset_vs_ce");

    // Release and take the first count on the next edge.
    @(negedge C1K);
    #1;
    RST = 1'b1;
    do_edge(1'b1, "first_after_release");
    push("first_after_release_const", 4'b0001, 4'b0001, 4'b0001);
    do_edge(1'b0, "hold_ce_low");

    // Let the monitor drain the queue.
    @(negedge C1K);
    #1;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
